// File: rtl/perf_pkg.sv
// Shared types and helpers for the multi-channel performance counter.
//   perf_state_t : counter FSM states
//   NIBBLE_W     : width of one hex/BCD digit
//   BCD_MAX_W    : widest counter the BCD helper supports
//   bcd_inc      : packed-BCD increment over the low `width` bits, returns {carry_out, value+1}
package perf_pkg;

    typedef enum logic [1:0] {IDLE, RUN, HOLD, DONE} perf_state_t;

    localparam int unsigned NIBBLE_W  = 4;
    localparam int unsigned BCD_MAX_W = 64;

    // Ripple a +1 through decimal digits; carry_out set only when every digit in range was 9.
    function automatic logic [BCD_MAX_W:0] bcd_inc(input logic [BCD_MAX_W-1:0] value,
                                                   input int unsigned           width);
        logic [BCD_MAX_W-1:0] res;
        logic                 carry;
        res   = value;
        carry = 1'b1;
        for (int unsigned i = 0; i < BCD_MAX_W / NIBBLE_W; i++) begin
            if (carry && (i * NIBBLE_W < width)) begin
                if (res[i*NIBBLE_W +: NIBBLE_W] == 4'd9) begin
                    res[i*NIBBLE_W +: NIBBLE_W] = 4'd0;
                end else begin
                    res[i*NIBBLE_W +: NIBBLE_W] = res[i*NIBBLE_W +: NIBBLE_W] + 4'd1;
                    carry = 1'b0;
                end
            end
        end
        return {carry, res};
    endfunction

endpackage

// File: rtl/perf_chan_counter.sv
// One saturating event counter channel with sticky overflow.
// Build option: PERF_BCD_EN selects packed-BCD counting (max all 9s) instead of binary (max all 1s).
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   clear      : synchronous zero of count and overflow, dominates inc
//   inc        : increment request this cycle
//   count      : current count
//   overflow   : set by an increment attempt while count is at max
module perf_chan_counter
    import perf_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             inc,
    output logic [WIDTH-1:0] count,
    output logic             overflow
);

    logic [WIDTH-1:0] count_next_c;
    logic             at_max_c;

`ifdef PERF_BCD_EN
    // BCD: the helper's carry-out doubles as the "all digits are 9" detect.
    always_comb begin
        count_next_c = WIDTH'(bcd_inc(BCD_MAX_W'(count), WIDTH));
        at_max_c     = 1'(bcd_inc(BCD_MAX_W'(count), WIDTH) >> BCD_MAX_W);
    end
`else
    always_comb begin
        count_next_c = count + WIDTH'(1);
        at_max_c     = &count;
    end
`endif

    // Saturate at max; the attempted increment only sets the sticky flag.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count    <= '0;
            overflow <= 1'b0;
        end else if (inc) begin
            if (at_max_c) begin
                overflow <= 1'b1;
            end else begin
                count <= count_next_c;
            end
        end
    end

endmodule

// File: rtl/perf_counter_multi.sv
// Multi-channel performance counter: counts CPU event streams from start until the PC
// parks at FINAL_PC for FINISH_HOLD cycles, then freezes and raises finished.
// Build option: PERF_BCD_EN makes all channels packed-BCD counters.
// Ports:
//   clk, reset : counter clock and synchronous active-high reset
//   start      : level, leaves IDLE when high
//   clear      : sync pulse, zeroes counters/overflow and returns to IDLE
//   pc         : CPU program counter
//   event_in   : per-channel increment enables
//   sel        : readout channel (out of range reads 0)
//   digit_sel  : nibble index of the selected count, 0 = LSN
//   count_out  : registered selected count
//   digit      : registered selected nibble
//   overflow   : sticky per-channel saturation flags
//   running    : high in RUN or HOLD
//   finished   : high in DONE
module perf_counter_multi
    import perf_pkg::*;
#(
    parameter int unsigned NUM_CHANNELS = 4,
    parameter int unsigned COUNT_WIDTH  = 32,
    parameter int unsigned PC_WIDTH     = 16,
    parameter int unsigned FINAL_PC     = 32'h0000_00FF,
    parameter int unsigned FINISH_HOLD  = 2,
    localparam int unsigned SEL_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1,
    localparam int unsigned DIG_W = (COUNT_WIDTH / NIBBLE_W > 1) ? $clog2(COUNT_WIDTH / NIBBLE_W) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    clear,
    input  logic [PC_WIDTH-1:0]     pc,
    input  logic [NUM_CHANNELS-1:0] event_in,
    input  logic [SEL_W-1:0]        sel,
    input  logic [DIG_W-1:0]        digit_sel,
    output logic [COUNT_WIDTH-1:0]  count_out,
    output logic [NIBBLE_W-1:0]     digit,
    output logic [NUM_CHANNELS-1:0] overflow,
    output logic                    running,
    output logic                    finished
);

    localparam int unsigned          HOLD_W     = $clog2(FINISH_HOLD + 1);
    localparam logic [PC_WIDTH-1:0]  FINAL_PC_T = PC_WIDTH'(FINAL_PC);

    perf_state_t                state;
    logic [HOLD_W-1:0]          hold_cnt;
    logic                       at_final_c;
    logic                       hold_done_c;
    logic                       count_en_c;
    logic [COUNT_WIDTH-1:0]     cnt [NUM_CHANNELS];
    logic [COUNT_WIDTH-1:0]     sel_val_c;
    logic [NIBBLE_W-1:0]        digit_c;

    assign at_final_c  = (pc == FINAL_PC_T);
    assign hold_done_c = (32'(hold_cnt) + 32'd1 >= FINISH_HOLD);
    // Clear suppresses the increment of the cycle it is asserted in.
    assign count_en_c  = ((state == RUN) || (state == HOLD)) && !clear;

    // Run/finish FSM; running/finished are registered alongside the state.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            state    <= IDLE;
            hold_cnt <= '0;
            running  <= 1'b0;
            finished <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= RUN;
                        running <= 1'b1;
                    end
                end
                RUN: begin
                    if (at_final_c) begin
                        if (FINISH_HOLD == 1) begin
                            state    <= DONE;
                            running  <= 1'b0;
                            finished <= 1'b1;
                        end else begin
                            state    <= HOLD;
                            hold_cnt <= HOLD_W'(1);
                        end
                    end
                end
                HOLD: begin
                    if (!at_final_c) begin
                        state    <= RUN;
                        hold_cnt <= '0;
                    end else if (hold_done_c) begin
                        state    <= DONE;
                        hold_cnt <= '0;
                        running  <= 1'b0;
                        finished <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                    end
                end
                DONE: begin
                end
                default: begin
                    state   <= IDLE;
                    running <= 1'b0;
                end
            endcase
        end
    end

    // One counter per event stream.
    for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_chan
        perf_chan_counter #(
            .WIDTH (COUNT_WIDTH)
        ) u_chan (
            .clk      (clk),
            .reset    (reset),
            .clear    (clear),
            .inc      (count_en_c && event_in[g]),
            .count    (cnt[g]),
            .overflow (overflow[g])
        );
    end

    // Readout mux; unmatched sel values fall through to 0.
    always_comb begin
        sel_val_c = '0;
        for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
            if (SEL_W'(i) == sel) begin
                sel_val_c = cnt[i];
            end
        end
        digit_c = NIBBLE_W'(sel_val_c >> (32'(digit_sel) * NIBBLE_W));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_out <= '0;
            digit     <= '0;
        end else begin
            count_out <= sel_val_c;
            digit     <= digit_c;
        end
    end

endmodule
